sha512_msg_seq: RTL and testbench
=================================

SHA512_MSG_SEQ -- requirements
Module: sha512_msg_seq

Interface
REQ-001 Parameter CNT_W, default 16: width of the accepted-chunk counter.
REQ-002 Parameter TIMEOUT, default 1023: maximum cycles allowed between core_start and core_done.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  in_chunk and in_last are valid.
REQ-006 in_ready  output  1  sequencer accepts a chunk this cycle.
REQ-007 in_chunk  input  1024  one padded 128-byte message block; bit 1023 is the first message bit.
REQ-008 in_last  input  1  the chunk is the final block of its message.
REQ-009 abort  input  1  discards the message in progress.
REQ-010 out_valid  output  1  out_digest holds a finished digest.
REQ-011 out_ready  input  1  consumer takes the digest.
REQ-012 out_digest  output  512  {H0..H7}; H0 occupies bits 511:448.
REQ-013 core_start  output  1  one-cycle pulse that launches the chunk compression core.
REQ-014 core_chunk  output  1024  registered copy of the accepted chunk.
REQ-015 core_h  output  512  chaining value {H0..H7} fed to the core.
REQ-016 core_done  input  1  core has finished; core_oh is valid.
REQ-017 core_oh  input  512  updated chaining value from the core, already including the feed-forward addition.
REQ-018 chunk_cnt  output  CNT_W  number of chunks accepted for the current message.
REQ-019 err_timeout  output  1  sticky flag; the core failed to finish within TIMEOUT cycles.

Function
REQ-020 States: IDLE, RUN, WAIT_NEXT, OUT, and no others.
REQ-021 In IDLE and WAIT_NEXT, in_ready SHALL be 1; in every other state it SHALL be 0.
REQ-022 When in_valid and in_ready are both high, the block SHALL latch in_chunk into core_chunk and latch in_last, increment chunk_cnt (saturating at all-ones), pulse core_start in the next cycle, and enter RUN.
REQ-023 core_chunk and core_h SHALL remain stable from the core_start pulse until core_done is sampled.
REQ-024 When core_done is sampled in RUN, core_h SHALL load core_oh; the next state SHALL be OUT if the latched last flag is 1, otherwise WAIT_NEXT.
REQ-025 core_done SHALL be ignored in every state other than RUN, including the core_start cycle itself.
REQ-026 In OUT, out_valid SHALL be 1 and out_digest SHALL equal core_h; both SHALL hold until out_ready is sampled high.
REQ-027 When out_valid and out_ready are both high, the block SHALL enter IDLE, reload core_h with the IV, and clear chunk_cnt; out_valid SHALL be 0 in the following cycle.
REQ-028 IV (H0..H7): 6a09e667f3bcc908, bb67ae8584caa73b, 3c6ef372fe94f82b, a54ff53a5f1d36f1, 510e527fade682d1, 9b05688c2b3e6c1f, 1f83d9abfb41bd6b, 5be0cd19137e2179.
REQ-029 A watchdog counter SHALL clear at core_start and increment in each RUN cycle; if it reaches TIMEOUT without core_done, err_timeout SHALL set and the block SHALL enter IDLE with the IV reloaded.
REQ-030 abort, in any state, SHALL send the block to IDLE on the next edge: IV reloaded, chunk_cnt cleared, out_valid 0, no core_start pulse. abort takes priority over a simultaneous handshake or core_done.
REQ-031 err_timeout SHALL be cleared only by reset or by an accepted chunk in IDLE.
REQ-032 All additions to core_h are performed by the core; this block performs no arithmetic on the chaining value.

Reset
REQ-033 While reset is high, the block SHALL hold IDLE with: in_ready 1, out_valid 0, core_start 0, core_h = IV, core_chunk 0, chunk_cnt 0, err_timeout 0, watchdog 0.
REQ-034 A reset asserted mid-message SHALL discard all state; core_done arriving after reset SHALL have no effect.

Verification
REQ-035 Single padded block for "abc" with last=1, driven into a reference core -> out_digest[511:448] = ddaf35a193617aba; chunk_cnt = 1.
REQ-036 Empty message (one pad block, last=1) -> out_digest[511:448] = cf83e1357eefb8bd.
REQ-037 Two-block message with out_ready held low for 5 cycles -> out_valid and out_digest stay constant for all 5 cycles; chunk_cnt = 2; in_ready = 0 throughout OUT.
REQ-038 Core model that never asserts core_done, TIMEOUT = 8 -> err_timeout = 1 exactly 8 RUN cycles after core_start; state returns to IDLE; core_h = IV.
REQ-039 abort asserted in the same cycle as core_done in RUN -> next cycle is IDLE, core_h = IV, out_valid 0, core_oh discarded.
REQ-040 Stray core_done pulse in IDLE or WAIT_NEXT -> core_h unchanged and no state change.

Source files
------------

// File: rtl/sha512_msg_seq.sv
// sha512_msg_seq
//   Message sequencer for a SHA-512 chunk compression core. Accepts padded
//   1024-bit blocks one at a time, hands each block plus the current chaining
//   value to the core, collects the updated chaining value, and presents the
//   final digest once the last block of a message has been compressed.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     block input handshake; in_chunk, in_last qualify it
//   abort                 drop the message in progress and return to idle
//   out_valid/out_ready   digest output handshake; out_digest = {H0..H7}
//   core_start            one-cycle launch pulse for the compression core
//   core_chunk, core_h    block and chaining value held for the core
//   core_done, core_oh    core completion strobe and updated chaining value
//   chunk_cnt             blocks accepted for the current message (saturating)
//   err_timeout           sticky: core did not finish within TIMEOUT cycles
module sha512_msg_seq #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1023:0]    in_chunk,
  input  logic             in_last,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [511:0]     out_digest,
  output logic             core_start,
  output logic [1023:0]    core_chunk,
  output logic [511:0]     core_h,
  input  logic             core_done,
  input  logic [511:0]     core_oh,
  output logic [CNT_W-1:0] chunk_cnt,
  output logic             err_timeout
);

  localparam logic [511:0] IV = {
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
    64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
    64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };

  // The watchdog holds the number of RUN cycles already completed for the
  // current block, so it never needs to represent TIMEOUT itself.
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_WAIT_NEXT,
    ST_OUT
  } state_t;

  state_t            state_q, state_d;
  logic [1023:0]     chunk_q, chunk_d;
  logic              last_q, last_d;
  logic [511:0]      h_q, h_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              start_q, start_d;
  logic              accept;

  assign in_ready    = (state_q == ST_IDLE) || (state_q == ST_WAIT_NEXT);
  assign out_valid   = (state_q == ST_OUT);
  assign out_digest  = h_q;
  assign core_start  = start_q;
  assign core_chunk  = chunk_q;
  assign core_h      = h_q;
  assign chunk_cnt   = cnt_q;
  assign err_timeout = err_q;
  assign accept      = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    chunk_d = chunk_q;
    last_d  = last_q;
    h_d     = h_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    wd_d    = wd_q;
    start_d = 1'b0;

    if (abort) begin
      // abort overrides any handshake or core completion in the same cycle
      state_d = ST_IDLE;
      h_d     = IV;
      cnt_d   = '0;
      wd_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_WAIT_NEXT: begin
          if (accept) begin
            chunk_d = in_chunk;
            last_d  = in_last;
            if (cnt_q != '1) begin
              cnt_d = cnt_q + 1'b1;
            end
            // A new message starting from idle clears a previous timeout.
            if (state_q == ST_IDLE) begin
              err_d = 1'b0;
            end
            start_d = 1'b1;
            wd_d    = '0;
            state_d = ST_RUN;
          end
        end

        ST_RUN: begin
          // core_done is not trusted in the launch cycle itself
          if (core_done && !start_q) begin
            h_d     = core_oh;
            wd_d    = '0;
            state_d = last_q ? ST_OUT : ST_WAIT_NEXT;
          end else if (wd_q == WD_LAST) begin
            // this RUN cycle is the TIMEOUT-th one without completion
            err_d   = 1'b1;
            h_d     = IV;
            cnt_d   = '0;
            wd_d    = '0;
            state_d = ST_IDLE;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end

        ST_OUT: begin
          if (out_ready) begin
            h_d     = IV;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
          h_d     = IV;
          cnt_d   = '0;
          wd_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      chunk_q <= '0;
      last_q  <= 1'b0;
      h_q     <= IV;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      wd_q    <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      chunk_q <= chunk_d;
      last_q  <= last_d;
      h_q     <= h_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
      start_q <= start_d;
    end
  end

endmodule

// File: tb/tb_sha512_msg_seq.sv
// tb_sha512_msg_seq
//   Drives padded blocks into sha512_msg_seq, emulates the compression core
//   with a real SHA-512 compression function, and checks the sequencer
//   against a message-level model: the digest of a message is the IV folded
//   through the compression function over its blocks.
module tb_sha512_msg_seq;

  localparam logic [511:0] IV = {
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
    64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
    64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };

  localparam logic [63:0] K [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  logic           clk;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [1023:0]  in_chunk;
  logic           in_last;
  logic           abort;
  logic           out_valid;
  logic           out_ready;
  logic [511:0]   out_digest;
  logic           core_start;
  logic [1023:0]  core_chunk;
  logic [511:0]   core_h;
  logic           core_done;
  logic [511:0]   core_oh;
  logic [1:0]     chunk_cnt;
  logic           err_timeout;

  int checks;
  int errors;

  // model state shared with the compare process
  logic           chk_en;
  logic           core_en;
  int             core_lat_force;
  logic [1023:0]  exp_chunk;
  logic [511:0]   exp_hin;
  logic [511:0]   exp_digest;
  logic [1:0]     exp_cnt;
  logic           cmp_busy;
  logic           cmp_hs;

  sha512_msg_seq #(
    .CNT_W   (2),
    .TIMEOUT (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_chunk    (in_chunk),
    .in_last     (in_last),
    .abort       (abort),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_digest  (out_digest),
    .core_start  (core_start),
    .core_chunk  (core_chunk),
    .core_h      (core_h),
    .core_done   (core_done),
    .core_oh     (core_oh),
    .chunk_cnt   (chunk_cnt),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- SHA-512 compression (reference core) ----------------
  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [511:0] sha512_compress(input logic [511:0] hin, input logic [1023:0] blk);
    logic [63:0] w [80];
    logic [63:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[1023 - 64*i -: 64];
    for (int i = 16; i < 80; i++) begin
      s0 = rotr(w[i-15], 1) ^ rotr(w[i-15], 8) ^ (w[i-15] >> 7);
      s1 = rotr(w[i-2], 19) ^ rotr(w[i-2], 61) ^ (w[i-2] >> 6);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, hh} = hin;
    for (int i = 0; i < 80; i++) begin
      t1 = hh + (rotr(e, 14) ^ rotr(e, 18) ^ rotr(e, 41)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (rotr(a, 28) ^ rotr(a, 34) ^ rotr(a, 39)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[511:448] + a, hin[447:384] + b, hin[383:320] + c, hin[319:256] + d,
            hin[255:192] + e, hin[191:128] + f, hin[127:64] + g, hin[63:0] + hh};
  endfunction

  function automatic logic [1023:0] rand_blk();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check_w(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_bit({tag, "_in_ready"}, in_ready, 1'b1);
    check_bit({tag, "_out_valid"}, out_valid, 1'b0);
    check_bit({tag, "_core_start"}, core_start, 1'b0);
    check_w({tag, "_core_h"}, core_h, IV);
    check_w({tag, "_chunk_hi"}, core_chunk[1023:512], '0);
    check_w({tag, "_chunk_lo"}, core_chunk[511:0], '0);
    check_w({tag, "_cnt"}, 512'(chunk_cnt), '0);
    check_bit({tag, "_err"}, err_timeout, 1'b0);
  endtask

  // ---------------- compare process ----------------
  initial begin
    cmp_busy = 1'b0;
    cmp_hs   = 1'b0;
    forever begin
      @(negedge clk);
      if (!chk_en) begin
        cmp_busy = 1'b0;
        cmp_hs   = 1'b0;
      end else begin
        if (cmp_hs) begin
          check_bit("post_hs_out_valid", out_valid, 1'b0);
          check_bit("post_hs_in_ready", in_ready, 1'b1);
          check_w("post_hs_cnt", 512'(chunk_cnt), '0);
          check_w("post_hs_core_h", core_h, IV);
        end
        if (core_start) begin
          cmp_busy = 1'b1;
          check_w("start_cnt", 512'(chunk_cnt), 512'(exp_cnt));
        end
        if (cmp_busy) begin
          check_w("run_core_h", core_h, exp_hin);
          check_w("run_chunk_hi", core_chunk[1023:512], exp_chunk[1023:512]);
          check_w("run_chunk_lo", core_chunk[511:0], exp_chunk[511:0]);
          check_bit("run_in_ready", in_ready, 1'b0);
        end
        if (out_valid) begin
          check_w("out_digest", out_digest, exp_digest);
          check_w("out_cnt", 512'(chunk_cnt), 512'(exp_cnt));
          check_bit("out_in_ready", in_ready, 1'b0);
        end
        if (core_done) cmp_busy = 1'b0;
        cmp_hs = out_valid && out_ready && !abort;
      end
    end
  end

  // ---------------- core model ----------------
  initial begin
    logic [511:0] res;
    int lat;
    core_done = 1'b0;
    core_oh   = '0;
    forever begin
      @(negedge clk);
      if (core_en && core_start) begin
        res = sha512_compress(core_h, core_chunk);
        lat = (core_lat_force != 0) ? core_lat_force : int'($urandom_range(1, 6));
        repeat (lat) @(posedge clk);
        #1;
        core_oh   = res;
        core_done = 1'b1;
        @(posedge clk);
        #1;
        core_done = 1'b0;
      end
    end
  end

  // ---------------- driver tasks (start and end at posedge + 1) ----------------
  task automatic send_chunk(input logic [1023:0] c, input logic last, input int gap,
                            input logic [511:0] hin, input logic [1:0] cnt);
    int n;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_chunk = c;
    in_last  = last;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_bit("chunk_accepted", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    exp_chunk = c;
    exp_hin   = hin;
    exp_cnt   = cnt;
  endtask

  task automatic recv(input int hold, output logic [511:0] dig, output logic [1:0] cnt);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_bit("out_valid_arrives", out_valid, 1'b1);
    dig = out_digest;
    cnt = chunk_cnt;
    if (!out_ready) begin
      for (int k = 0; k < hold; k++) @(posedge clk);
      #1;
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_msg(input int n, input int hold, input logic early);
    logic [1023:0] blk [5];
    logic [511:0]  h, dig;
    logic [1:0]    cnt, ec;
    h = IV;
    for (int k = 0; k < n; k++) begin
      blk[k] = rand_blk();
      h = sha512_compress(h, blk[k]);
    end
    exp_digest = h;
    h = IV;
    for (int k = 0; k < n; k++) begin
      ec = (k + 1 >= 3) ? 2'd3 : 2'(k + 1);
      if (k == n - 1 && early) out_ready = 1'b1;
      send_chunk(blk[k], (k == n - 1), int'($urandom_range(0, 2)), h, ec);
      h = sha512_compress(h, blk[k]);
    end
    recv(hold, dig, cnt);
    $display("msg blocks=%0d hold=%0d early=%0d cnt=%0d digest_hi=%h", n, hold, early, cnt, dig[511:448]);
  endtask

  task automatic do_timeout();
    send_chunk(rand_blk(), 1'b1, 0, IV, 2'd1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) check_bit("to_start_pulse", core_start, 1'b1);
      check_bit("to_err_early", err_timeout, 1'b0);
      check_bit("to_in_ready_run", in_ready, 1'b0);
    end
    @(negedge clk);
    check_bit("to_err_set", err_timeout, 1'b1);
    check_bit("to_idle", in_ready, 1'b1);
    check_w("to_core_h_iv", core_h, IV);
    check_bit("to_out_valid", out_valid, 1'b0);
    $display("timeout err_timeout=%b core_h_hi=%h", err_timeout, core_h[511:448]);
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [1023:0] c0, c1, abc_blk, empty_blk;
    logic [511:0]  h1, dig, junk;
    logic [1:0]    cnt;
    int n;

    checks = 0; errors = 0;
    chk_en = 1'b0; core_en = 1'b0; core_lat_force = 0;
    reset = 1'b1; in_valid = 1'b0; in_chunk = '0; in_last = 1'b0;
    abort = 1'b0; out_ready = 1'b0;
    exp_chunk = '0; exp_hin = IV; exp_digest = '0; exp_cnt = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("rst");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // known-answer blocks: "abc" and the empty message
    abc_blk = '0;
    abc_blk[1023:1000] = 24'h616263;
    abc_blk[999:992]   = 8'h80;
    abc_blk[7:0]       = 8'h18;
    empty_blk = '0;
    empty_blk[1023] = 1'b1;
    check_w("model_abc", 512'(sha512_compress(IV, abc_blk) >> 448), 512'(64'hddaf35a193617aba));
    check_w("model_empty", 512'(sha512_compress(IV, empty_blk) >> 448), 512'(64'hcf83e1357eefb8bd));

    chk_en = 1'b1; core_en = 1'b1;
    exp_digest = sha512_compress(IV, abc_blk);
    send_chunk(abc_blk, 1'b1, 0, IV, 2'd1);
    recv(1, dig, cnt);
    check_w("abc_digest_hi", 512'(dig[511:448]), 512'(64'hddaf35a193617aba));
    check_w("abc_cnt", 512'(cnt), 512'(2'd1));
    $display("msg abc digest_hi=%h cnt=%0d", dig[511:448], cnt);

    exp_digest = sha512_compress(IV, empty_blk);
    send_chunk(empty_blk, 1'b1, 1, IV, 2'd1);
    recv(2, dig, cnt);
    check_w("empty_digest_hi", 512'(dig[511:448]), 512'(64'hcf83e1357eefb8bd));
    $display("msg empty digest_hi=%h cnt=%0d", dig[511:448], cnt);

    // two-block message, stray core_done while waiting for block 2, digest held 5 cycles
    c0 = rand_blk();
    c1 = rand_blk();
    h1 = sha512_compress(IV, c0);
    exp_digest = sha512_compress(h1, c1);
    send_chunk(c0, 1'b0, 0, IV, 2'd1);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_bit("wn_reached", in_ready, 1'b1);
    @(posedge clk);
    #1;
    junk = rand_blk();
    core_oh = junk;
    core_done = 1'b1;
    @(posedge clk);
    #1;
    core_done = 1'b0;
    @(negedge clk);
    check_bit("stray_wn_in_ready", in_ready, 1'b1);
    check_w("stray_wn_core_h", core_h, h1);
    check_bit("stray_wn_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    send_chunk(c1, 1'b1, 0, h1, 2'd2);
    recv(5, dig, cnt);
    check_w("two_blk_cnt", 512'(cnt), 512'(2'd2));
    $display("msg two_block hold=5 digest_hi=%h cnt=%0d", dig[511:448], cnt);

    // completion on the last cycle before the watchdog limit
    core_lat_force = 7;
    run_msg(1, 1, 1'b0);
    check_bit("lat7_no_timeout", err_timeout, 1'b0);
    core_lat_force = 0;

    for (int m = 0; m < 12; m++) begin
      run_msg(int'($urandom_range(1, 5)), int'($urandom_range(1, 5)), ($urandom_range(0, 3) == 0));
    end

    // directed cases below use explicit checks only
    chk_en = 1'b0; core_en = 1'b0;

    // stray core_done in IDLE
    junk = rand_blk();
    core_oh = junk;
    core_done = 1'b1;
    @(posedge clk);
    #1;
    core_done = 1'b0;
    @(negedge clk);
    check_w("stray_idle_core_h", core_h, IV);
    check_bit("stray_idle_in_ready", in_ready, 1'b1);
    check_bit("stray_idle_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;

    // watchdog expiry; abort leaves the flag set, reset clears it
    do_timeout();
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    check_bit("err_after_abort", err_timeout, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_state("rst_idle");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // second expiry; the next accepted block clears the flag; abort beats core_done
    do_timeout();
    send_chunk(rand_blk(), 1'b1, 0, IV, 2'd1);
    @(negedge clk);
    check_bit("err_clr_on_accept", err_timeout, 1'b0);
    @(posedge clk);
    #1;
    junk = rand_blk();
    core_oh = junk;
    core_done = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    core_done = 1'b0;
    abort = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_bit("abort_done_in_ready", in_ready, 1'b1);
      check_bit("abort_done_out_valid", out_valid, 1'b0);
      check_w("abort_done_core_h", core_h, IV);
      check_w("abort_done_cnt", 512'(chunk_cnt), '0);
    end
    $display("abort with core_done core_h_hi=%h out_valid=%b", core_h[511:448], out_valid);
    @(posedge clk);
    #1;

    // abort beats an input handshake in IDLE
    in_valid = 1'b1;
    in_chunk = rand_blk();
    in_last = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check_bit("abort_hs_no_start", core_start, 1'b0);
    check_bit("abort_hs_in_ready", in_ready, 1'b1);
    check_w("abort_hs_cnt", 512'(chunk_cnt), '0);
    @(posedge clk);
    #1;

    // abort while the digest is waiting in OUT
    core_en = 1'b1;
    send_chunk(rand_blk(), 1'b1, 0, IV, 2'd1);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_bit("abort_out_reached", out_valid, 1'b1);
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    check_bit("abort_out_valid", out_valid, 1'b0);
    check_w("abort_out_core_h", core_h, IV);
    check_w("abort_out_cnt", 512'(chunk_cnt), '0);
    @(posedge clk);
    #1;
    core_en = 1'b0;

    // reset mid-message, then a late core_done
    send_chunk(rand_blk(), 1'b0, 0, IV, 2'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_state("rst_mid");
    @(posedge clk);
    #1;
    reset = 1'b0;
    junk = rand_blk();
    core_oh = junk;
    core_done = 1'b1;
    @(posedge clk);
    #1;
    core_done = 1'b0;
    @(negedge clk);
    check_w("late_done_core_h", core_h, IV);
    check_bit("late_done_in_ready", in_ready, 1'b1);
    check_bit("late_done_out_valid", out_valid, 1'b0);
    $display("reset mid-message core_h_hi=%h in_ready=%b", core_h[511:448], in_ready);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit actual=running required=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
